// File: rtl/pc_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_types
//   Shared types for the fetch-PC redirect controller.
//   - redirect_class_t : source of a redirect, ordered by priority
//   - redirect_t       : one pending redirect entry
//   - ctrl_state_t     : RUN / IDLE_WAIT / IDLE sequencing state
//   - RDR_KILL_CYCLES  : default length of the post-flush fetch kill window
//   - RDR_TARGET_W     : container width for targets. Every instance narrows
//                        it to its own PC_WIDTH, which must not exceed this.
// ---------------------------------------------------------------------------
package pipeline_types;

    localparam int RDR_KILL_CYCLES = 2;
    localparam int RDR_TARGET_W    = 64;

    typedef enum logic [1:0] {
        RDR_NONE = 2'd0,
        RDR_BR   = 2'd1,
        RDR_ERTN = 2'd2,
        RDR_EXC  = 2'd3
    } redirect_class_t;

    typedef struct packed {
        logic                    valid;
        redirect_class_t         cls;
        logic [RDR_TARGET_W-1:0] target;
        logic                    is_int;
    } redirect_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IDLE_WAIT = 2'd1,
        IDLE      = 2'd2
    } ctrl_state_t;

    localparam redirect_t RDR_EMPTY = '{
        valid:  1'b0,
        cls:    RDR_NONE,
        target: '0,
        is_int: 1'b0
    };

    // is_int only carries meaning for exceptions; it is forced low otherwise.
    function automatic redirect_t make_redirect(
        input redirect_class_t         cls,
        input logic [RDR_TARGET_W-1:0] target,
        input logic                    is_int
    );
        redirect_t r;
        r.valid  = 1'b1;
        r.cls    = cls;
        r.target = target;
        r.is_int = (cls == RDR_EXC) ? is_int : 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// redirect_arbiter
//   Combinational. Merges this cycle's redirect requests into the current
//   pending entry and returns the next pending entry.
//   Ports:
//     exc_valid/exc_target/exc_is_int : exception / interrupt request
//     ertn_valid/ertn_target          : ertn request
//     br_valid/br_target              : branch mispredict request
//     cur                             : pending entry to merge into (already
//                                       emptied by the caller if it is being
//                                       consumed this cycle)
//     nxt                             : resulting pending entry
// ---------------------------------------------------------------------------
module redirect_arbiter
    import pipeline_types::*;
(
    input  logic                    exc_valid,
    input  logic [RDR_TARGET_W-1:0] exc_target,
    input  logic                    exc_is_int,
    input  logic                    ertn_valid,
    input  logic [RDR_TARGET_W-1:0] ertn_target,
    input  logic                    br_valid,
    input  logic [RDR_TARGET_W-1:0] br_target,
    input  redirect_t               cur,
    output redirect_t               nxt
);

    // Only the highest-priority request is considered. A lower one can never
    // succeed where a higher one was refused, so the if-chain is exact.
    always_comb begin
        // NOTE: nxt gets a full default first so no path through the if-chain
        // leaves it unassigned; that is what keeps this block free of latches.
        nxt = cur;
        if (exc_valid) begin
            // Exceptions overwrite anything, including an older exception.
            nxt = make_redirect(RDR_EXC, exc_target, exc_is_int);
        end else if (ertn_valid) begin
            if (!cur.valid || cur.cls == RDR_BR) begin
                nxt = make_redirect(RDR_ERTN, ertn_target, 1'b0);
            end
        end else if (br_valid) begin
            if (!cur.valid) begin
                nxt = make_redirect(RDR_BR, br_target, 1'b0);
            end
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//   Sequences the fetch PC register: arbitrates redirect requests, holds the
//   winner until the PC register takes it, handles IDLE and the kill window
//   for fetches that were in flight when a redirect was taken.
//   Ports:
//     clk, rst_n                     : clock, async active-low reset
//     exc_valid/exc_target/exc_is_int: exception / interrupt redirect pulse
//     ertn_valid/ertn_target         : ertn redirect pulse
//     br_valid/br_target             : branch mispredict redirect pulse
//     idle_req                       : IDLE instruction committed
//     backend_pause, icache_stall    : stall sources
//     pc_flush/pc_pause/pc_new_pc/pc_is_interrupt : PC register controls
//     fetch_kill                     : drop fetch results this cycle
//     idle_active                    : core is sitting in IDLE
//   Parameters:
//     KILL_CYCLES : kill window length after a consumed redirect (1..7)
//     PC_WIDTH    : width of PC/target buses (at most RDR_TARGET_W)
// ---------------------------------------------------------------------------
module pc_redirect_ctrl
    import pipeline_types::*;
#(
    parameter int KILL_CYCLES = RDR_KILL_CYCLES,
    parameter int PC_WIDTH    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                exc_valid,
    input  logic [PC_WIDTH-1:0] exc_target,
    input  logic                exc_is_int,
    input  logic                ertn_valid,
    input  logic [PC_WIDTH-1:0] ertn_target,
    input  logic                br_valid,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                idle_req,
    input  logic                backend_pause,
    input  logic                icache_stall,
    output logic                pc_flush,
    output logic                pc_pause,
    output logic [PC_WIDTH-1:0] pc_new_pc,
    output logic                pc_is_interrupt,
    output logic                fetch_kill,
    output logic                idle_active
);

    localparam int CNT_W = 3;

    redirect_t               pending_q, pending_d, arb_base;
    ctrl_state_t             state_q, state_d;
    logic [CNT_W-1:0]        kill_q, kill_d;
    logic                    idle_active_q, idle_active_d;
    logic                    in_idle;
    logic                    consume;
    logic [RDR_TARGET_W-1:0] exc_tgt_ext, ertn_tgt_ext, br_tgt_ext;
    logic                    unused_target_bits;

    // Targets travel in the package-wide container; upper bits stay zero.
    always_comb begin
        exc_tgt_ext                 = '0;
        ertn_tgt_ext                = '0;
        br_tgt_ext                  = '0;
        exc_tgt_ext[PC_WIDTH-1:0]   = exc_target;
        ertn_tgt_ext[PC_WIDTH-1:0]  = ertn_target;
        br_tgt_ext[PC_WIDTH-1:0]    = br_target;
    end

    assign in_idle  = (state_q == IDLE);
    assign pc_pause = backend_pause | icache_stall | in_idle;
    assign consume  = pending_q.valid & ~pc_pause;

    // A request arriving in the consuming cycle merges into an empty entry,
    // which is what allows back-to-back flushes.
    assign arb_base = consume ? RDR_EMPTY : pending_q;

    // In IDLE only an exception may wake the core; ertn and branch requests
    // are squashed before they reach the arbiter.
    redirect_arbiter u_arbiter (
        .exc_valid   (exc_valid),
        .exc_target  (exc_tgt_ext),
        .exc_is_int  (exc_is_int),
        .ertn_valid  (ertn_valid & ~in_idle),
        .ertn_target (ertn_tgt_ext),
        .br_valid    (br_valid & ~in_idle),
        .br_target   (br_tgt_ext),
        .cur         (arb_base),
        .nxt         (pending_d)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            // An exception in the same cycle wins over IDLE; the idle is lost.
            RUN:       if (idle_req && !exc_valid) state_d = IDLE_WAIT;
            // Looking at the next entry guarantees IDLE is entered with
            // nothing pending, since IDLE forces pause and could never drain.
            IDLE_WAIT: if (!pending_d.valid)       state_d = IDLE;
            IDLE:      if (exc_valid)              state_d = RUN;
            default:                               state_d = RUN;
        endcase
    end

    assign idle_active_d = (state_d == IDLE);

    // Reload, never accumulate, on each consumption.
    always_comb begin
        if (consume) begin
            kill_d = CNT_W'(KILL_CYCLES);
        end else if (kill_q != '0) begin
            kill_d = kill_q - 3'd1;
        end else begin
            kill_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= RDR_EMPTY;
            state_q       <= RUN;
            kill_q        <= '0;
            idle_active_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            pending_q     <= pending_d;
            state_q       <= state_d;
            kill_q        <= kill_d;
            idle_active_q <= idle_active_d;
        end
    end

    assign pc_flush        = pending_q.valid;
    assign pc_new_pc       = pending_q.target[PC_WIDTH-1:0];
    assign pc_is_interrupt = pending_q.is_int;
    assign fetch_kill      = (kill_q != '0) | pending_q.valid;
    assign idle_active     = idle_active_q;

    // Container bits above PC_WIDTH are always zero and deliberately unread.
    assign unused_target_bits = ^pending_q.target;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//   Directed scenarios plus a randomized run against a behavioural model.
//   The model tracks the pending redirect by priority rank (BR=1, ERTN=2,
//   EXC=3). A new request replaces the entry if the entry is empty, if the
//   request outranks it, or if the request is an exception.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

    localparam int KILL = 2;
    localparam int W    = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         exc_valid, exc_is_int, ertn_valid, br_valid, idle_req;
    logic [W-1:0] exc_target, ertn_target, br_target;
    logic         backend_pause, icache_stall;
    logic         pc_flush, pc_pause, pc_is_interrupt, fetch_kill, idle_active;
    logic [W-1:0] pc_new_pc;

    int errors = 0;
    int checks = 0;

    // Behavioural model state. m_mode: 0 run, 1 waiting for idle, 2 idle.
    bit           m_valid;
    int           m_rank;
    logic [W-1:0] m_target;
    bit           m_int;
    int           m_mode;
    int           m_cnt;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.KILL_CYCLES(KILL), .PC_WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .exc_valid       (exc_valid),
        .exc_target      (exc_target),
        .exc_is_int      (exc_is_int),
        .ertn_valid      (ertn_valid),
        .ertn_target     (ertn_target),
        .br_valid        (br_valid),
        .br_target       (br_target),
        .idle_req        (idle_req),
        .backend_pause   (backend_pause),
        .icache_stall    (icache_stall),
        .pc_flush        (pc_flush),
        .pc_pause        (pc_pause),
        .pc_new_pc       (pc_new_pc),
        .pc_is_interrupt (pc_is_interrupt),
        .fetch_kill      (fetch_kill),
        .idle_active     (idle_active)
    );

    task automatic model_reset();
        m_valid  = 0;
        m_rank   = 0;
        m_target = '0;
        m_int    = 0;
        m_mode   = 0;
        m_cnt    = 0;
    endtask

    function automatic bit model_pause();
        return backend_pause || icache_stall || (m_mode == 2);
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_update();
        int           req_rank;
        logic [W-1:0] req_tgt;
        bit           req_int;
        bit           taken;
        bit           base_valid;
        if (!rst_n) begin
            model_reset();
            return;
        end
        taken    = m_valid && !model_pause();
        req_rank = 0;
        req_tgt  = '0;
        req_int  = 0;
        if (exc_valid) begin
            req_rank = 3; req_tgt = exc_target; req_int = exc_is_int;
        end else if (ertn_valid && m_mode != 2) begin
            req_rank = 2; req_tgt = ertn_target;
        end else if (br_valid && m_mode != 2) begin
            req_rank = 1; req_tgt = br_target;
        end
        base_valid = m_valid && !taken;
        if (req_rank != 0 && (!base_valid || req_rank > m_rank || req_rank == 3)) begin
            m_valid = 1; m_rank = req_rank; m_target = req_tgt; m_int = req_int;
        end else if (!base_valid) begin
            m_valid = 0; m_rank = 0; m_target = '0; m_int = 0;
        end
        case (m_mode)
            0: if (idle_req && !exc_valid) m_mode = 1;
            1: if (!m_valid) m_mode = 2;
            default: if (exc_valid) m_mode = 0;
        endcase
        if (taken) m_cnt = KILL;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
    endtask

    // One clock: model follows the edge, pulse inputs drop just after it.
    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        exc_valid  = 1'b0;
        ertn_valid = 1'b0;
        br_valid   = 1'b0;
        idle_req   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (pc_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", pc_flush); end
        checks++; if (pc_pause !== 1'b0) begin errors++; $display("FAIL reset_pause: got %b want 0", pc_pause); end
        checks++; if (pc_new_pc !== '0) begin errors++; $display("FAIL reset_new_pc: got %h want 0", pc_new_pc); end
        checks++; if (pc_is_interrupt !== 1'b0) begin errors++; $display("FAIL reset_is_int: got %b want 0", pc_is_interrupt); end
        checks++; if (fetch_kill !== 1'b0) begin errors++; $display("FAIL reset_kill: got %b want 0", fetch_kill); end
        checks++; if (idle_active !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b want 0", idle_active); end
        cyc();
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_single_redirect();
        logic [3:0] kill_exp;
        kill_exp = 4'b0111;
        br_valid = 1'b1; br_target = 32'h1c00_0100;
        cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (pc_flush !== (i == 0)) begin errors++; $display("FAIL single_flush[%0d]: got %b want %b", i, pc_flush, (i == 0)); end
            if (i == 0) begin
                checks++; if (pc_new_pc !== 32'h1c00_0100) begin errors++; $display("FAIL single_new_pc: got %h want 1c000100", pc_new_pc); end
            end
            checks++; if (fetch_kill !== kill_exp[i]) begin errors++; $display("FAIL single_kill[%0d]: got %b want %b", i, fetch_kill, kill_exp[i]); end
            cyc();
        end
    endtask

    task automatic test_simultaneous();
        exc_valid  = 1'b1; exc_target  = 32'h1c00_8000; exc_is_int = 1'b1;
        ertn_valid = 1'b1; ertn_target = 32'h1c00_0200;
        br_valid   = 1'b1; br_target   = 32'h1c00_0300;
        cyc();
        exc_is_int = 1'b0;
        @(negedge clk);
        checks++; if (pc_flush !== 1'b1) begin errors++; $display("FAIL simul_flush: got %b want 1", pc_flush); end
        checks++; if (pc_new_pc !== 32'h1c00_8000) begin errors++; $display("FAIL simul_new_pc: got %h want 1c008000", pc_new_pc); end
        checks++; if (pc_is_interrupt !== 1'b1) begin errors++; $display("FAIL simul_is_int: got %b want 1", pc_is_interrupt); end
        idle_cycles(4);
    endtask

    // exc_at < 0 means no exception arrives during the stall.
    task automatic test_held_stall(input int exc_at);
        logic [W-1:0] want;
        br_valid = 1'b1; br_target = 32'h100;
        cyc();
        icache_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == exc_at) begin
                exc_valid = 1'b1; exc_target = 32'h2000; exc_is_int = 1'b0;
            end
            want = (exc_at >= 0 && i > exc_at) ? 32'h2000 : 32'h100;
            @(negedge clk);
            checks++; if (pc_flush !== 1'b1) begin errors++; $display("FAIL stall_flush[%0d]: got %b want 1", i, pc_flush); end
            checks++; if (pc_pause !== 1'b1) begin errors++; $display("FAIL stall_pause[%0d]: got %b want 1", i, pc_pause); end
            checks++; if (pc_new_pc !== want) begin errors++; $display("FAIL stall_new_pc[%0d]: got %h want %h", i, pc_new_pc, want); end
            cyc();
        end
        icache_stall = 1'b0;
        want = (exc_at >= 0) ? 32'h2000 : 32'h100;
        @(negedge clk);
        checks++; if (pc_flush !== 1'b1 || pc_pause !== 1'b0) begin errors++; $display("FAIL stall_consume: got flush=%b pause=%b want flush=1 pause=0", pc_flush, pc_pause); end
        checks++; if (pc_new_pc !== want) begin errors++; $display("FAIL stall_consume_pc: got %h want %h", pc_new_pc, want); end
        cyc();
        @(negedge clk);
        checks++; if (pc_flush !== 1'b0) begin errors++; $display("FAIL stall_after: got %b want 0", pc_flush); end
        idle_cycles(3);
    endtask

    task automatic test_drop_rule();
        backend_pause = 1'b1;
        ertn_valid = 1'b1; ertn_target = 32'h300;
        cyc();
        br_valid = 1'b1; br_target = 32'h400;
        @(negedge clk);
        checks++; if (pc_new_pc !== 32'h300) begin errors++; $display("FAIL drop_pending: got %h want 300", pc_new_pc); end
        cyc();
        backend_pause = 1'b0;
        @(negedge clk);
        checks++; if (pc_flush !== 1'b1 || pc_new_pc !== 32'h300) begin errors++; $display("FAIL drop_consume: got flush=%b pc=%h want flush=1 pc=300", pc_flush, pc_new_pc); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (pc_flush !== 1'b0) begin errors++; $display("FAIL drop_no_second[%0d]: got %b want 0", i, pc_flush); end
            cyc();
        end
    endtask

    task automatic test_idle();
        idle_req = 1'b1;
        cyc();
        cyc();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                br_valid = 1'b1; br_target = 32'h500;
            end
            if (i == 6) begin
                ertn_valid = 1'b1; ertn_target = 32'h600;
            end
            @(negedge clk);
            checks++; if (idle_active !== 1'b1 || pc_pause !== 1'b1) begin errors++; $display("FAIL idle_window[%0d]: got idle=%b pause=%b want 1 1", i, idle_active, pc_pause); end
            checks++; if (pc_flush !== 1'b0) begin errors++; $display("FAIL idle_ignore[%0d]: got flush=%b want 0", i, pc_flush); end
            cyc();
        end
        exc_valid = 1'b1; exc_target = 32'h8000; exc_is_int = 1'b1;
        cyc();
        exc_is_int = 1'b0;
        @(negedge clk);
        checks++; if (idle_active !== 1'b0) begin errors++; $display("FAIL idle_wake: got idle=%b want 0", idle_active); end
        checks++; if (pc_flush !== 1'b1 || pc_new_pc !== 32'h8000 || pc_is_interrupt !== 1'b1) begin
            errors++; $display("FAIL idle_exc: got flush=%b pc=%h int=%b want 1 8000 1", pc_flush, pc_new_pc, pc_is_interrupt);
        end
        idle_cycles(4);
    endtask

    task automatic test_back_to_back();
        logic [3:0] kill_exp;
        kill_exp = 4'b0011;
        br_valid = 1'b1; br_target = 32'haaa0;
        cyc();
        br_valid = 1'b1; br_target = 32'hbbb0;
        @(negedge clk);
        checks++; if (pc_flush !== 1'b1 || pc_new_pc !== 32'haaa0) begin errors++; $display("FAIL b2b_first: got flush=%b pc=%h want 1 aaa0", pc_flush, pc_new_pc); end
        cyc();
        @(negedge clk);
        checks++; if (pc_flush !== 1'b1 || pc_new_pc !== 32'hbbb0) begin errors++; $display("FAIL b2b_second: got flush=%b pc=%h want 1 bbb0", pc_flush, pc_new_pc); end
        cyc();
        // Reload (not accumulate): kill high for exactly KILL cycles after the second flush.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (fetch_kill !== kill_exp[i]) begin errors++; $display("FAIL b2b_kill[%0d]: got %b want %b", i, fetch_kill, kill_exp[i]); end
            cyc();
        end
    endtask

    task automatic test_async_reset();
        br_valid = 1'b1; br_target = 32'h100;
        cyc();
        icache_stall = 1'b1;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (pc_flush !== 1'b0 || pc_new_pc !== '0 || pc_is_interrupt !== 1'b0) begin
            errors++; $display("FAIL areset_pending: got flush=%b pc=%h int=%b want 0 0 0", pc_flush, pc_new_pc, pc_is_interrupt);
        end
        checks++; if (fetch_kill !== 1'b0 || idle_active !== 1'b0) begin errors++; $display("FAIL areset_misc: got kill=%b idle=%b want 0 0", fetch_kill, idle_active); end
        icache_stall = 1'b0;
        #1;
        checks++; if (pc_pause !== 1'b0) begin errors++; $display("FAIL areset_pause: got %b want 0", pc_pause); end
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (pc_flush !== 1'b0) begin errors++; $display("FAIL areset_no_flush[%0d]: got %b want 0", i, pc_flush); end
            cyc();
        end
    endtask

    task automatic test_random(input int n);
        logic [W-1:0] exp_pc;
        for (int i = 0; i < n; i++) begin
            exc_valid     = ($urandom_range(0, 9) == 0);
            exc_target    = $urandom;
            exc_is_int    = $urandom_range(0, 1) == 1;
            ertn_valid    = ($urandom_range(0, 7) == 0);
            ertn_target   = $urandom;
            br_valid      = ($urandom_range(0, 3) == 0);
            br_target     = $urandom;
            idle_req      = ($urandom_range(0, 19) == 0);
            backend_pause = ($urandom_range(0, 4) == 0);
            icache_stall  = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            exp_pc = m_valid ? m_target : '0;
            checks++; if (pc_flush !== m_valid) begin errors++; $display("FAIL rand_flush @%0d: got %b want %b", i, pc_flush, m_valid); end
            checks++; if (pc_new_pc !== exp_pc) begin errors++; $display("FAIL rand_new_pc @%0d: got %h want %h", i, pc_new_pc, exp_pc); end
            checks++; if (pc_is_interrupt !== (m_valid && m_int)) begin errors++; $display("FAIL rand_is_int @%0d: got %b want %b", i, pc_is_interrupt, m_valid && m_int); end
            checks++; if (pc_pause !== model_pause()) begin errors++; $display("FAIL rand_pause @%0d: got %b want %b", i, pc_pause, model_pause()); end
            checks++; if (fetch_kill !== (m_cnt != 0 || m_valid)) begin errors++; $display("FAIL rand_kill @%0d: got %b want %b", i, fetch_kill, (m_cnt != 0 || m_valid)); end
            checks++; if (idle_active !== (m_mode == 2)) begin errors++; $display("FAIL rand_idle @%0d: got %b want %b", i, idle_active, (m_mode == 2)); end
            cyc();
        end
        backend_pause = 1'b0;
        icache_stall  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exc_valid = 1'b0; exc_target = '0; exc_is_int = 1'b0;
        ertn_valid = 1'b0; ertn_target = '0;
        br_valid = 1'b0; br_target = '0;
        idle_req = 1'b0; backend_pause = 1'b0; icache_stall = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_single_redirect();
        test_simultaneous();
        test_held_stall(-1);
        test_held_stall(1);
        test_drop_rule();
        test_idle();
        test_back_to_back();
        test_async_reset();
        test_random(800);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Sequences the fetch PC register. It collects redirect requests from three sources (exception/interrupt from CSR, ertn from CSR, branch mispredict from execute) and arbitrates them by priority. It holds the winning redirect until the PC register can accept it, and drives the PC register's flush/pause/new_pc/is_interrupt controls. It also implements IDLE wait and a post-flush kill window for in-flight fetches.

Parameters:
KILL_CYCLES, 2, cycles fetch_kill stays high after a redirect is consumed (1..7)
PC_WIDTH, 32, width of all PC/target buses

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
exc_valid  input  1  exception/interrupt redirect request (single-cycle pulse)
exc_target  input  PC_WIDTH  exception entry address
exc_is_int  input  1  request is an interrupt
ertn_valid  input  1  ertn redirect request (pulse)
ertn_target  input  PC_WIDTH  ERA value
br_valid  input  1  branch mispredict redirect request (pulse)
br_target  input  PC_WIDTH  corrected target
idle_req  input  1  IDLE instruction committed (pulse)
backend_pause  input  1  backend stall
icache_stall  input  1  instruction fetch stall
pc_flush  output  1  to PC register flush
pc_pause  output  1  to PC register pause
pc_new_pc  output  PC_WIDTH  to PC register new_pc
pc_is_interrupt  output  1  to PC register is_interrupt
fetch_kill  output  1  discard fetch results this cycle
idle_active  output  1  core is in IDLE

Behaviour:
- Reset (async, rst_n=0): state RUN, pending empty, pc_flush=0, pc_new_pc=0, pc_is_interrupt=0, fetch_kill=0, idle_active=0, kill counter=0. pc_pause=0 in this state.
- Priority for same-cycle requests: exc > ertn > br. Only one request is latched per cycle.
- Pending register fields: valid, class (EXC/ERTN/BR), target, is_int.
- A request in cycle N is latched at the edge ending N. pc_flush and pc_new_pc come from the pending register, so pc_flush is high in N+1 (1-cycle latency).
- Consumption: a redirect is consumed in a cycle where pc_flush=1 and pc_pause=0. The pending register clears at the end of that cycle.
- While not consumed, pc_flush, pc_new_pc and pc_is_interrupt hold stable.
- Pending overwrite rules:
  - exc overwrites any pending class.
  - ertn overwrites a pending BR only.
  - br is dropped whenever pending is valid.
  - A request arriving in the consuming cycle is evaluated against the empty register and latched, so back-to-back flushes are possible.
- pc_pause = backend_pause | icache_stall | (state==IDLE), all combinational.
- State machine:
  - RUN: on idle_req, go to IDLE_WAIT. If idle_req arrives together with exc_valid, the exc is latched and the idle is dropped (stay RUN).
  - IDLE_WAIT: entered with pending possibly valid. Go to IDLE once pending is empty. Requests are still accepted.
  - IDLE: idle_active=1, pc_pause=1. br_valid and ertn_valid are ignored. exc_valid latches and moves the state to RUN in the same edge. Its flush is consumable from the next cycle unless stalled.
- Kill counter:
  - Loads KILL_CYCLES on each consumption.
  - Decrements when nonzero.
  - fetch_kill = (counter != 0) | pc_flush.
  - A new consumption while counting reloads the counter; it does not add.
- Width: targets pass through unmodified with no alignment check. is_int is meaningful only for class EXC, and 0 otherwise.
- Reset mid-operation: pending, counter and state are discarded immediately and asynchronously.

Decomposition:
- Shared package (pipeline_types):
  - redirect_class_t enum {RDR_NONE, RDR_BR, RDR_ERTN, RDR_EXC}
  - redirect_t struct {valid, cls, target, is_int}
  - ctrl_state_t enum {RUN, IDLE_WAIT, IDLE}
  - RDR_KILL_CYCLES default constant
- One sub-module is natural: redirect_arbiter. It is combinational: it takes the three requests plus the current pending entry and returns the next pending entry. The top level holds the registers, FSM and counter.

Test Plan:
- Single redirect: br_valid=1, br_target=0x1c000100 in cycle 5, no stall -> pc_flush=1, pc_new_pc=0x1c000100 in cycle 6 only. fetch_kill high in cycles 6,7,8 (KILL_CYCLES=2); low in cycle 9.
- Simultaneous requests: exc(0x1c008000, is_int=1), ertn(0x1c000200) and br(0x1c000300) all in one cycle -> next cycle pc_new_pc=0x1c008000, pc_is_interrupt=1.
- Held under stall:
  - br(0x100) latched, icache_stall high for 4 cycles -> pc_flush and pc_new_pc=0x100 stable for 4 cycles with pc_pause=1, consumed on the first cycle the stall is low.
  - Repeat with exc(0x2000) arriving mid-stall -> pc_new_pc switches to 0x2000 and 0x100 is never consumed.
- Drop rule: pending ertn(0x300) under backend_pause, then br(0x400) arrives -> consumed value is 0x300; no second flush follows.
- IDLE:
  - idle_req -> idle_active=1 and pc_pause=1 for 10 cycles. A br_valid during this window is ignored.
  - exc_valid(0x8000, is_int=1) -> next cycle idle_active=0, pc_flush=1, pc_new_pc=0x8000, pc_is_interrupt=1.
- Async reset: rst_n low mid-stall with pending valid -> all outputs 0 immediately. After release, no flush is emitted until a new request arrives.
